// File: rtl/fpu_issue_ctrl.sv
// Issue/retire controller between FP decode and the FP ALU.
// Holds one operation's operands and op code stable for the op-specific ALU
// latency, then captures the result and folds exception flags into fflags.
module fpu_issue_ctrl #(
  parameter int unsigned LAT_ADDSUB = 7,
  parameter int unsigned LAT_MUL    = 5,
  parameter int unsigned LAT_DIV    = 6,
  parameter int unsigned LAT_SQRT   = 16,
  parameter int unsigned LAT_CVT    = 6,
  parameter int unsigned LAT_CMP    = 1
) (
  input  logic        iclock,
  input  logic        irst_n,
  input  logic        istart,
  input  logic [4:0]  icontrol,
  input  logic [31:0] idataa,
  input  logic [31:0] idatab,
  input  logic        iclearflags,
  output logic [31:0] ofpa,
  output logic [31:0] ofpb,
  output logic [4:0]  ofpcontrol,
  input  logic [31:0] ifpresult,
  input  logic        ifpnan,
  input  logic        ifpzero,
  input  logic        ifpoverflow,
  input  logic        ifpunderflow,
  input  logic        ifpcomp,
  output logic        obusy,
  output logic        odone,
  output logic [31:0] oresult,
  output logic        ocompresult,
  output logic        ozero,
  output logic [4:0]  oflags
);

  // FP ALU op codes
  localparam logic [4:0] FOPADD    = 5'd0;
  localparam logic [4:0] FOPSUB    = 5'd1;
  localparam logic [4:0] FOPMUL    = 5'd2;
  localparam logic [4:0] FOPDIV    = 5'd3;
  localparam logic [4:0] FOPSQRT   = 5'd4;
  localparam logic [4:0] FOPCEQ    = 5'd10;
  localparam logic [4:0] FOPCLT    = 5'd11;
  localparam logic [4:0] FOPCLE    = 5'd12;
  localparam logic [4:0] FOPMAX    = 5'd13;
  localparam logic [4:0] FOPMIN    = 5'd14;
  localparam logic [4:0] FOPCVTSW  = 5'd15;
  localparam logic [4:0] FOPCVTWS  = 5'd16;
  localparam logic [4:0] FOPCVTSWU = 5'd17;
  localparam logic [4:0] FOPCVTWUS = 5'd18;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0] state_q;
  logic [4:0] cnt_q;
  logic [4:0] lat_m1;
  logic       accept;
  logic       capture;
  logic       div_by_zero;
  logic [4:0] flags_d;

  // Counter preload (latency minus one) for the incoming op code
  always_comb begin
    lat_m1 = 5'd0;
    case (icontrol)
      FOPADD, FOPSUB:                           lat_m1 = 5'(LAT_ADDSUB - 1);
      FOPMUL:                                   lat_m1 = 5'(LAT_MUL - 1);
      FOPDIV:                                   lat_m1 = 5'(LAT_DIV - 1);
      FOPSQRT:                                  lat_m1 = 5'(LAT_SQRT - 1);
      FOPCVTSW, FOPCVTWS, FOPCVTSWU, FOPCVTWUS: lat_m1 = 5'(LAT_CVT - 1);
      FOPCEQ, FOPCLT, FOPCLE, FOPMAX, FOPMIN:   lat_m1 = 5'(LAT_CMP - 1);
      default:                                  lat_m1 = 5'd0;
    endcase
  end

  // Accept only outside BUSY; capture only on BUSY's final edge, so they never coincide
  assign accept  = istart && (state_q != StBusy);
  assign capture = (state_q == StBusy) && (cnt_q == 5'd0);
  assign obusy   = (state_q == StBusy);
  assign odone   = (state_q == StDone);

  // Divide-by-zero: finite non-zero dividend over a signed zero divisor
  assign div_by_zero = (ofpcontrol == FOPDIV) && (ofpb[30:0] == 31'd0) &&
                       (ofpa[30:23] != 8'hFF) && (ofpa[30:0] != 31'd0);

  // Sticky flags: clear first, then OR in this edge's capture
  always_comb begin
    flags_d = iclearflags ? 5'd0 : oflags;
    if (capture) begin
      flags_d = flags_d | {ifpnan, div_by_zero, ifpoverflow, ifpunderflow, 1'b0};
    end
  end

  // Control FSM and latency counter
  always_ff @(posedge iclock or negedge irst_n) begin
    if (!irst_n) begin
      state_q <= StIdle;
      cnt_q   <= 5'd0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (accept) begin
            state_q <= StBusy;
            cnt_q   <= lat_m1;
          end else begin
            state_q <= StIdle;
          end
        end
        StBusy: begin
          if (cnt_q == 5'd0) begin
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= 5'd0;
        end
      endcase
    end
  end

  // Operand and op registers in front of the ALU
  always_ff @(posedge iclock or negedge irst_n) begin
    if (!irst_n) begin
      ofpa       <= 32'd0;
      ofpb       <= 32'd0;
      ofpcontrol <= 5'd0;
    end else if (accept) begin
      ofpa       <= idataa;
      ofpb       <= idatab;
      ofpcontrol <= icontrol;
    end
  end

  // Result capture at retire
  always_ff @(posedge iclock or negedge irst_n) begin
    if (!irst_n) begin
      oresult     <= 32'd0;
      ocompresult <= 1'b0;
      ozero       <= 1'b0;
    end else if (capture) begin
      oresult     <= ifpresult;
      ocompresult <= ifpcomp;
      ozero       <= ifpzero;
    end
  end

  // Accrued exception flags {NV, DZ, OF, UF, NX}
  always_ff @(posedge iclock or negedge irst_n) begin
    if (!irst_n) begin
      oflags <= 5'd0;
    end else begin
      oflags <= flags_d;
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: directed scenarios plus random traffic,
// all compared each cycle against an edge-numbered behavioural model.
module tb_fpu_issue_ctrl;

  localparam int LAT_ADDSUB = 7;
  localparam int LAT_MUL    = 5;
  localparam int LAT_DIV    = 6;
  localparam int LAT_SQRT   = 16;
  localparam int LAT_CVT    = 6;
  localparam int LAT_CMP    = 1;

  localparam logic [4:0] FOPADD  = 5'd0;
  localparam logic [4:0] FOPSUB  = 5'd1;
  localparam logic [4:0] FOPMUL  = 5'd2;
  localparam logic [4:0] FOPDIV  = 5'd3;
  localparam logic [4:0] FOPSQRT = 5'd4;
  localparam logic [4:0] FOPCLT  = 5'd11;

  logic        iclock = 1'b0;
  logic        irst_n;
  logic        istart;
  logic [4:0]  icontrol;
  logic [31:0] idataa, idatab;
  logic        iclearflags;
  logic [31:0] ofpa, ofpb;
  logic [4:0]  ofpcontrol;
  logic [31:0] ifpresult;
  logic        ifpnan, ifpzero, ifpoverflow, ifpunderflow, ifpcomp;
  logic        obusy, odone;
  logic [31:0] oresult;
  logic        ocompresult, ozero;
  logic [4:0]  oflags;

  int checks = 0;
  int errors = 0;

  fpu_issue_ctrl #(
    .LAT_ADDSUB(LAT_ADDSUB), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV),
    .LAT_SQRT(LAT_SQRT), .LAT_CVT(LAT_CVT), .LAT_CMP(LAT_CMP)
  ) dut (
    .iclock(iclock), .irst_n(irst_n), .istart(istart), .icontrol(icontrol),
    .idataa(idataa), .idatab(idatab), .iclearflags(iclearflags),
    .ofpa(ofpa), .ofpb(ofpb), .ofpcontrol(ofpcontrol),
    .ifpresult(ifpresult), .ifpnan(ifpnan), .ifpzero(ifpzero),
    .ifpoverflow(ifpoverflow), .ifpunderflow(ifpunderflow), .ifpcomp(ifpcomp),
    .obusy(obusy), .odone(odone), .oresult(oresult), .ocompresult(ocompresult),
    .ozero(ozero), .oflags(oflags)
  );

  always #5 iclock = ~iclock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input logic [4:0] c);
    case (c)
      5'd0, 5'd1:                 return LAT_ADDSUB;
      5'd2:                       return LAT_MUL;
      5'd3:                       return LAT_DIV;
      5'd4:                       return LAT_SQRT;
      5'd15, 5'd16, 5'd17, 5'd18: return LAT_CVT;
      5'd10, 5'd11, 5'd12, 5'd13, 5'd14: return LAT_CMP;
      default:                    return 1;
    endcase
  endfunction

  // Model: an op accepted at edge acc retires at edge acc+lat; busy in between.
  int          e = 0;
  bit          m_have;
  int          m_acc, m_ret;
  logic [31:0] m_a, m_b, m_res;
  logic [4:0]  m_ctrl, m_flags;
  logic        m_comp, m_zero;

  task automatic model_reset();
    m_have = 0; m_acc = 0; m_ret = 0;
    m_a = 0; m_b = 0; m_ctrl = 0; m_res = 0; m_comp = 0; m_zero = 0; m_flags = 0;
  endtask

  // Advance the model on each edge, then compare every output just after it
  initial begin
    bit busy_before, capture, dz;
    model_reset();
    forever begin
      @(posedge iclock);
      if (!irst_n) begin
        model_reset();
      end else begin
        e++;
        busy_before = m_have && (e - 1 >= m_acc) && (e - 1 < m_ret);
        capture     = m_have && (e == m_ret);
        dz = (m_ctrl == FOPDIV) && (m_b[30:0] == 0) && (m_a[30:23] != 8'hFF) &&
             (m_a[30:0] != 0);
        if (iclearflags) m_flags = 0;
        if (capture) begin
          m_flags = m_flags | {ifpnan, dz, ifpoverflow, ifpunderflow, 1'b0};
          m_res = ifpresult; m_comp = ifpcomp; m_zero = ifpzero;
        end
        if (istart && !busy_before) begin
          m_a = idataa; m_b = idatab; m_ctrl = icontrol;
          m_acc = e; m_ret = e + lat_of(icontrol); m_have = 1;
        end
      end
      #1;
      chk("obusy", 32'(obusy), 32'(m_have && e >= m_acc && e < m_ret));
      chk("odone", 32'(odone), 32'(m_have && e == m_ret));
      chk("ofpa", ofpa, m_a);
      chk("ofpb", ofpb, m_b);
      chk("ofpcontrol", 32'(ofpcontrol), 32'(m_ctrl));
      chk("oresult", oresult, m_res);
      chk("ocompresult", 32'(ocompresult), 32'(m_comp));
      chk("ozero", 32'(ozero), 32'(m_zero));
      chk("oflags", 32'(oflags), 32'(m_flags));
    end
  end

  task automatic issue(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    icontrol = c; idataa = a; idatab = b; istart = 1'b1;
    @(negedge iclock);
    istart = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (odone) begin
        seen = 1;
        break;
      end
      @(negedge iclock);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout actual=no_odone required=odone", name);
    end
  endtask

  initial begin
    int n;
    irst_n = 0; istart = 0; icontrol = 0; idataa = 0; idatab = 0; iclearflags = 0;
    ifpresult = 0; ifpnan = 0; ifpzero = 0; ifpoverflow = 0; ifpunderflow = 0; ifpcomp = 0;
    repeat (2) @(negedge iclock);
    chk("rst_obusy", 32'(obusy), 0);
    chk("rst_odone", 32'(odone), 0);
    chk("rst_oflags", 32'(oflags), 0);
    chk("rst_ofpa", ofpa, 0);
    irst_n = 1;
    @(negedge iclock);

    // FOPADD latency 7
    ifpresult = 32'h4040_0000;
    issue(FOPADD, 32'h3F80_0000, 32'h4000_0000);
    for (int k = 0; k <= LAT_ADDSUB; k++) begin
      chk("add_busy", 32'(obusy), 32'(k < LAT_ADDSUB));
      chk("add_done", 32'(odone), 32'(k == LAT_ADDSUB));
      if (k < LAT_ADDSUB) @(negedge iclock);
    end
    chk("add_result", oresult, 32'h4040_0000);
    chk("add_ofpa", ofpa, 32'h3F80_0000);
    @(negedge iclock);

    // Divide by zero, then overflow accumulates
    issue(FOPDIV, 32'h3F80_0000, 32'h8000_0000);
    wait_done("div_done");
    chk("div_flags", 32'(oflags), 32'b01000);
    @(negedge iclock);
    ifpoverflow = 1;
    issue(FOPMUL, 32'h4000_0000, 32'h4000_0000);
    wait_done("mul_done");
    chk("mul_flags", 32'(oflags), 32'b01100);
    ifpoverflow = 0;
    @(negedge iclock);

    // istart during BUSY is ignored
    issue(FOPMUL, 32'h1111_1111, 32'h3333_3333);
    idataa = 32'h2222_2222; istart = 1;
    @(negedge iclock);
    istart = 0;
    @(negedge iclock);
    istart = 1;
    @(negedge iclock);
    istart = 0;
    n = 0;
    repeat (8) begin
      if (odone) n++;
      @(negedge iclock);
    end
    chk("ignore_done_count", n, 1);
    chk("ignore_ofpa", ofpa, 32'h1111_1111);

    // Back-to-back: issue in the DONE cycle
    ifpcomp = 0;
    issue(FOPMUL, 32'h4000_0000, 32'h4040_0000);
    wait_done("b2b_first");
    ifpcomp = 1;
    issue(FOPCLT, 32'h3F80_0000, 32'h4000_0000);
    chk("b2b_gap_done", 32'(odone), 0);
    chk("b2b_gap_busy", 32'(obusy), 1);
    @(negedge iclock);
    chk("b2b_second_done", 32'(odone), 1);
    chk("b2b_comp", 32'(ocompresult), 1);
    ifpcomp = 0;
    @(negedge iclock);

    // Clear coinciding with a capture
    iclearflags = 1;
    @(negedge iclock);
    iclearflags = 0;
    chk("clear_flags", 32'(oflags), 0);
    ifpoverflow = 1; ifpunderflow = 1;
    issue(FOPMUL, 32'h7F00_0000, 32'h7F00_0000);
    wait_done("ofuf_done");
    chk("ofuf_flags", 32'(oflags), 32'b00110);
    ifpoverflow = 0; ifpunderflow = 0; ifpnan = 1;
    @(negedge iclock);
    issue(FOPSQRT, 32'hBF80_0000, 32'h0);
    repeat (LAT_SQRT - 1) @(negedge iclock);
    iclearflags = 1;
    @(negedge iclock);
    iclearflags = 0; ifpnan = 0;
    chk("sqrt_done", 32'(odone), 1);
    chk("sqrt_flags", 32'(oflags), 32'b10000);
    @(negedge iclock);

    // Reset mid-op
    issue(FOPMUL, 32'h5555_5555, 32'hAAAA_AAAA);
    @(negedge iclock);
    irst_n = 0;
    #1;
    chk("midrst_obusy", 32'(obusy), 0);
    chk("midrst_ofpa", ofpa, 0);
    chk("midrst_ofpb", ofpb, 0);
    chk("midrst_oresult", oresult, 0);
    chk("midrst_oflags", 32'(oflags), 0);
    @(negedge iclock);
    irst_n = 1;
    n = 0;
    repeat (8) begin
      if (odone) n++;
      @(negedge iclock);
    end
    chk("midrst_no_done", n, 0);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      istart       = ($urandom_range(0, 2) == 0);
      icontrol     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 4))
                                                 : 5'($urandom_range(0, 31));
      idataa       = ($urandom_range(0, 7) == 0) ? 32'h7F80_0000 : $urandom;
      idatab       = ($urandom_range(0, 3) == 0) ? {1'($urandom), 31'd0} : $urandom;
      iclearflags  = ($urandom_range(0, 15) == 0);
      ifpresult    = $urandom;
      ifpnan       = ($urandom_range(0, 7) == 0);
      ifpzero      = 1'($urandom);
      ifpoverflow  = ($urandom_range(0, 7) == 0);
      ifpunderflow = ($urandom_range(0, 7) == 0);
      ifpcomp      = 1'($urandom);
      irst_n       = ($urandom_range(0, 399) != 0);
      @(negedge iclock);
    end
    irst_n = 1; istart = 0; iclearflags = 0;
    repeat (20) @(negedge iclock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
